// File: rtl/btb_bht_predictor_if.sv
// Fetch/decode-facing bundle of the branch predictor: lookup request, prediction,
// resolution feedback, flush and busy status.
interface btb_bht_predictor_if #(
  parameter int AW = 32
);
  logic          lookup_valid;
  logic [AW-1:0] lookup_pc;
  logic          pred_valid;
  logic          pred_hit;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic [AW-1:0] next_pc;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_target;
  logic          upd_taken;
  logic          flush;
  logic          busy;

  // Fetch/decode side
  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
    input  pred_valid, pred_hit, pred_taken, pred_target, next_pc, busy
  );

  // Predictor side
  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
    output pred_valid, pred_hit, pred_taken, pred_target, next_pc, busy
  );
endinterface

// File: rtl/btb_bht_predictor.sv
// Direct-mapped tagged BTB plus 2-bit saturating-counter BHT with a registered
// one-cycle lookup and a flush sweep that clears one entry of each table per cycle.
module btb_bht_predictor #(
  parameter int         AW          = 32,
  parameter int         BTB_ENTRIES = 16,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  btb_bht_predictor_if.slave   bus
);

  localparam int IDX_W   = $clog2(BTB_ENTRIES);
  localparam int HIDX_W  = $clog2(BHT_ENTRIES);
  localparam int TAG_W   = AW - IDX_W - 2;
  localparam int SWEEP_N = (BTB_ENTRIES > BHT_ENTRIES) ? BTB_ENTRIES : BHT_ENTRIES;
  localparam int CNT_W   = $clog2(SWEEP_N);

  localparam logic [CNT_W:0]   BTB_LIM   = (CNT_W+1)'(BTB_ENTRIES);
  localparam logic [CNT_W:0]   BHT_LIM   = (CNT_W+1)'(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] SWEEP_MAX = CNT_W'(SWEEP_N - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  // Table storage
  logic             r_btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] r_btb_tag    [BTB_ENTRIES];
  logic [AW-1:0]    r_btb_target [BTB_ENTRIES];
  logic [1:0]       r_bht        [BHT_ENTRIES];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_sweep_cnt;
  logic             w_busy;

  logic             r_pred_valid;
  logic             r_pred_hit;
  logic             r_pred_taken;
  logic [AW-1:0]    r_pred_target;
  logic [AW-1:0]    r_next_pc;

  // Address decomposition
  logic [IDX_W-1:0]  w_lk_btb_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [HIDX_W-1:0] w_lk_bht_idx;
  logic [IDX_W-1:0]  w_up_btb_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic [HIDX_W-1:0] w_up_bht_idx;
  logic              w_unused;

  assign w_lk_btb_idx = bus.lookup_pc[IDX_W+1:2];
  assign w_lk_tag     = bus.lookup_pc[AW-1:IDX_W+2];
  assign w_lk_bht_idx = bus.lookup_pc[HIDX_W+1:2];
  assign w_up_btb_idx = bus.upd_pc[IDX_W+1:2];
  assign w_up_tag     = bus.upd_pc[AW-1:IDX_W+2];
  assign w_up_bht_idx = bus.upd_pc[HIDX_W+1:2];
  assign w_unused     = ^bus.upd_pc[1:0];

  // Control qualifiers: flush beats a same-cycle update, and the sweep owns the tables.
  logic w_start_sweep;
  logic w_upd_en;
  logic w_sweep_last;
  logic w_sweep_btb;
  logic w_sweep_bht;

  assign w_start_sweep = (r_state == S_IDLE) && bus.flush;
  assign w_upd_en      = (r_state == S_IDLE) && !bus.flush && bus.upd_valid;
  assign w_sweep_last  = (r_sweep_cnt == SWEEP_MAX);
  assign w_sweep_btb   = w_busy && ({1'b0, r_sweep_cnt} < BTB_LIM);
  assign w_sweep_bht   = w_busy && ({1'b0, r_sweep_cnt} < BHT_LIM);

  // ---------------- Flush sweep FSM ----------------
  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.flush)   w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_sweep_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_SWEEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_sweep_cnt <= '0;
    else if (w_start_sweep) r_sweep_cnt <= '0;
    else if (w_busy)        r_sweep_cnt <= r_sweep_cnt + 1'b1;
  end

  // ---------------- BTB ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb_valid[i] <= 1'b0;
    end else if (w_sweep_btb) begin
      r_btb_valid[r_sweep_cnt[IDX_W-1:0]] <= 1'b0;
    end else if (w_upd_en && bus.upd_taken) begin
      r_btb_valid[w_up_btb_idx] <= 1'b1;
    end
  end

  // NOTE: tag/target storage is not reset; the valid bits alone decide whether it is ever read.
  always_ff @(posedge clk) begin
    if (w_upd_en && bus.upd_taken) begin
      r_btb_tag[w_up_btb_idx]    <= w_up_tag;
      r_btb_target[w_up_btb_idx] <= bus.upd_target;
    end
  end

  // ---------------- BHT ----------------
  logic [1:0] w_ctr_old;
  logic [1:0] w_ctr_new;

  assign w_ctr_old = r_bht[w_up_bht_idx];

  always_comb begin
    w_ctr_new = w_ctr_old;
    if (bus.upd_taken && (w_ctr_old != 2'b11))       w_ctr_new = w_ctr_old + 2'b01;
    else if (!bus.upd_taken && (w_ctr_old != 2'b00)) w_ctr_new = w_ctr_old - 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (w_sweep_bht) begin
      r_bht[r_sweep_cnt[HIDX_W-1:0]] <= CTR_INIT;
    end else if (w_upd_en) begin
      r_bht[w_up_bht_idx] <= w_ctr_new;
    end
  end

  // ---------------- Lookup ----------------
  // Tables are read before any same-edge write lands, so a colliding update shows next lookup.
  logic          w_hit;
  logic          w_taken;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_next_pc;

  assign w_hit     = !w_busy && r_btb_valid[w_lk_btb_idx] && (r_btb_tag[w_lk_btb_idx] == w_lk_tag);
  assign w_taken   = w_hit && r_bht[w_lk_bht_idx][1];
  assign w_target  = w_hit ? r_btb_target[w_lk_btb_idx] : '0;
  assign w_next_pc = w_taken ? w_target : (bus.lookup_pc + AW'(4));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
      r_next_pc     <= '0;
    end else begin
      r_pred_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        r_pred_hit    <= w_hit;
        r_pred_taken  <= w_taken;
        r_pred_target <= w_target;
        r_next_pc     <= w_next_pc;
      end
    end
  end

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_hit    = r_pred_hit;
  assign bus.pred_taken  = r_pred_taken;
  assign bus.pred_target = r_pred_target;
  assign bus.next_pc     = r_next_pc;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_btb_bht_predictor.sv
// Self-checking bench for btb_bht_predictor: directed vector table, flush and
// reset-mid-sweep sequences, then randomized traffic against a table-level model.
module tb_btb_bht_predictor;

  localparam int AW    = 32;
  localparam int NBTB  = 16;
  localparam int NBHT  = 64;
  localparam int SWEEP = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  btb_bht_predictor_if #(.AW(AW)) bus();

  btb_bht_predictor #(
    .AW(AW), .BTB_ENTRIES(NBTB), .BHT_ENTRIES(NBHT), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: tables as plain arrays, the flush sweep as a countdown.
  bit          m_valid [NBTB];
  logic [31:0] m_tag   [NBTB];
  logic [31:0] m_tgt   [NBTB];
  int          m_ctr   [NBHT];
  int          sweep_left;

  bit          e_pv, e_hit, e_taken;
  logic [31:0] e_target, e_next;

  function automatic int btb_idx(logic [31:0] pc);
    return int'((pc / 4) % NBTB);
  endfunction

  function automatic int bht_idx(logic [31:0] pc);
    return int'((pc / 4) % NBHT);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (4 * NBTB);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBTB; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < NBHT; i++) m_ctr[i] = 1;
    sweep_left = 0;
    e_pv = 0; e_hit = 0; e_taken = 0; e_target = '0; e_next = '0;
  endtask

  task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input bit utk, input bit fl);
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.upd_valid    = uv;
    bus.upd_pc       = upc;
    bus.upd_target   = utgt;
    bus.upd_taken    = utk;
    bus.flush        = fl;
  endtask

  task automatic check_outputs();
    check("pred_valid",  64'(bus.pred_valid),  64'(e_pv));
    check("pred_hit",    64'(bus.pred_hit),    64'(e_hit));
    check("pred_taken",  64'(bus.pred_taken),  64'(e_taken));
    check("pred_target", 64'(bus.pred_target), 64'(e_target));
    check("next_pc",     64'(bus.next_pc),     64'(e_next));
    check("busy",        64'(bus.busy),        64'(sweep_left > 0));
  endtask

  // One clock: predict from pre-edge model state, apply the edge's table effects, then compare.
  task automatic cycle();
    bit busy_now;
    int bi, hi;
    busy_now = (sweep_left > 0);
    e_pv = bus.lookup_valid;
    if (bus.lookup_valid) begin
      bi       = btb_idx(bus.lookup_pc);
      hi       = bht_idx(bus.lookup_pc);
      e_hit    = !busy_now && m_valid[bi] && (m_tag[bi] == tag_of(bus.lookup_pc));
      e_taken  = e_hit && (m_ctr[hi] >= 2);
      e_target = e_hit ? m_tgt[bi] : 32'h0;
      e_next   = e_taken ? e_target : bus.lookup_pc + 32'd4;
    end
    if (busy_now) begin
      sweep_left--;
    end else if (bus.flush) begin
      for (int i = 0; i < NBTB; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < NBHT; i++) m_ctr[i] = 1;
      sweep_left = SWEEP;
    end else if (bus.upd_valid) begin
      hi = bht_idx(bus.upd_pc);
      m_ctr[hi] = bus.upd_taken ? ((m_ctr[hi] < 3) ? m_ctr[hi] + 1 : 3)
                                : ((m_ctr[hi] > 0) ? m_ctr[hi] - 1 : 0);
      if (bus.upd_taken) begin
        bi = btb_idx(bus.upd_pc);
        m_valid[bi] = 1'b1;
        m_tag[bi]   = tag_of(bus.upd_pc);
        m_tgt[bi]   = bus.upd_target;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  typedef struct {
    bit          lv;
    logic [31:0] lpc;
    bit          uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    bit          utk;
    bit          x_hit;
    bit          x_taken;
    logic [31:0] x_target;
    logic [31:0] x_next;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, logic [31:0] utgt,
                              bit utk, bit xh, bit xt, logic [31:0] xtg, logic [31:0] xn);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk;
    v.x_hit = xh; v.x_taken = xt; v.x_target = xtg; v.x_next = xn;
    return v;
  endfunction

  function automatic logic [31:0] pick_pc();
    int          sel;
    logic [31:0] base;
    sel = int'($urandom_range(0, 19));
    if (sel == 0) return 32'hFFFF_FFFC;
    base = (sel < 10) ? 32'h1000 : ((sel < 15) ? 32'h1040 : 32'h8000);
    return base + (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int r;
    model_reset();

    // Reset held with inputs toggling: every output stays zero.
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      check_outputs();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Directed vectors, table empty and all counters weakly not-taken at start.
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0,                     0, 0, 32'h0,    32'h1004));
    vecs.push_back(mk(0, 0,        1, 32'h1000, 32'h2000, 1,       0, 0, 0,        0));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0,                     1, 1, 32'h2000, 32'h2000));
    vecs.push_back(mk(0, 0,        1, 32'h1000, 32'h2000, 0,       0, 0, 0,        0));
    vecs.push_back(mk(0, 0,        1, 32'h1000, 32'h2000, 0,       0, 0, 0,        0));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0,                     1, 0, 32'h2000, 32'h1004));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,      1, 32'h1000, 32'h2000, 1,       0, 0, 0,        0));
    vecs.push_back(mk(0, 0,        1, 32'h1000, 32'h2000, 0,       0, 0, 0,        0));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0,                     1, 1, 32'h2000, 32'h2000));
    vecs.push_back(mk(0, 0,        1, 32'h1040, 32'h3000, 1,       0, 0, 0,        0));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0,                     0, 0, 32'h0,    32'h1004));
    vecs.push_back(mk(1, 32'h1040, 0, 0, 0, 0,                     1, 1, 32'h3000, 32'h3000));
    vecs.push_back(mk(1, 32'h1000, 1, 32'h1000, 32'h5000, 1,       0, 0, 32'h0,    32'h1004));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0,                     1, 1, 32'h5000, 32'h5000));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0,                0, 0, 32'h0,    32'h0));

    foreach (vecs[k]) begin
      drive(vecs[k].lv, vecs[k].lpc, vecs[k].uv, vecs[k].upc, vecs[k].utgt, vecs[k].utk, 1'b0);
      cycle();
      check($sformatf("vec%0d_pv", k), 64'(bus.pred_valid), 64'(vecs[k].lv));
      if (vecs[k].lv) begin
        check($sformatf("vec%0d_hit", k),    64'(bus.pred_hit),    64'(vecs[k].x_hit));
        check($sformatf("vec%0d_taken", k),  64'(bus.pred_taken),  64'(vecs[k].x_taken));
        check($sformatf("vec%0d_target", k), 64'(bus.pred_target), 64'(vecs[k].x_target));
        check($sformatf("vec%0d_next", k),   64'(bus.next_pc),     64'(vecs[k].x_next));
      end
    end

    // Flush with a same-cycle update: update lost, busy for exactly SWEEP cycles, lookups miss.
    drive(1, 32'h1000, 1, 32'h1000, 32'h7000, 1, 1);
    cycle();
    check("flush_edge_old_pred", 64'(bus.next_pc), 64'h5000);
    bc = int'(bus.busy);
    drive(1, 32'h1000, 0, 0, 0, 0, 0);
    for (int i = 0; i < SWEEP + 6; i++) begin
      cycle();
      bc += int'(bus.busy);
    end
    check("busy_len", 64'(bc), 64'(SWEEP));
    cycle();
    check("post_flush_hit",  64'(bus.pred_hit), 64'h0);
    check("post_flush_next", 64'(bus.next_pc),  64'h1004);

    // Reset asserted partway through a sweep aborts it immediately.
    drive(0, 0, 1, 32'h1000, 32'h2000, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_mid_busy", 64'(bus.busy), 64'h0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    cycle();
    check("wrap_hit",  64'(bus.pred_hit), 64'h0);
    check("wrap_next", 64'(bus.next_pc),  64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      drive(1'($urandom), pick_pc(), r < 45, pick_pc(), $urandom & 32'hFFFF_FFFC,
            1'($urandom), r == 99);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
